button_event: RTL and testbench
===============================

# button_event

Press-classification stage that sits directly downstream of the switch debouncer. It consumes the debouncer's clean, clk-synchronous `debounced` level and turns it into one-cycle event pulses: short press, long press and double press. It also keeps a wrapping count of all presses for LED and seven-segment display logic.

## Interface
- `LONG_CYCLES`, default 25_000_000: consecutive high samples that make a press "long"; must be ≥ 2.
- `GAP_CYCLES`, default 5_000_000: consecutive low samples after a release that close the double-press window; must be ≥ 2.
- `CNT_WIDTH`, default 8: width of `press_count`.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `debounced` in 1: button level, high = pressed; already synchronous to `clk` (driven by the debouncer), so no synchroniser.
- `short_press` out 1: one-cycle pulse, single short press completed.
- `long_press` out 1: one-cycle pulse, press held `LONG_CYCLES` samples.
- `double_press` out 1: one-cycle pulse, second press of a pair released.
- `press_count` out `CNT_WIDTH`: count of rising edges on `debounced`; wraps modulo 2^`CNT_WIDTH`.

## Operation
- Reset values: all pulse outputs 0, `press_count` 0, state IDLE, timer 0, previous-sample register 0.
  - Because the previous sample resets to 0, an input already high at reset release counts as a press.
- Timer width is $clog2(max(`LONG_CYCLES`,`GAP_CYCLES`)+1).
  - The timer counts consecutive samples of the current level, and is loaded with 1 on each state entry below.
- Every rising edge (sample high, previous sample low) increments `press_count`, in any state.
- State IDLE:
  - High sample → PRESSED, timer = 1.
- State PRESSED:
  - High sample with timer+1 == `LONG_CYCLES` → assert `long_press`, go to LONG_HELD.
  - Other high samples → timer++.
  - Low sample → WAIT_SECOND, timer = 1.
- State LONG_HELD:
  - Low sample → IDLE. No other event is emitted for this press.
- State WAIT_SECOND:
  - Low sample with timer+1 == `GAP_CYCLES` → assert `short_press`, go to IDLE.
  - Other low samples → timer++.
  - High sample → SECOND_PRESSED, timer = 1.
- State SECOND_PRESSED:
  - Low sample → assert `double_press`, go to IDLE.
  - High sample reaching `LONG_CYCLES` → assert `long_press`, go to LONG_HELD. The pending double press is discarded.
- At most one event pulse is asserted per cycle.
- Event pulses are registered outputs and are never combinational from `debounced`.

## Timing
- A sample is the value of `debounced` at a `clk` rising edge.
- An event pulse is high for exactly the one cycle following the edge that decides it.
- `press_count` updates at the edge that samples the rising edge, so it is visible 1 cycle later.
- `long_press` follows the `LONG_CYCLES`-th consecutive high sample.
  - A press of `LONG_CYCLES`-1 samples is short.
- `short_press` follows the `GAP_CYCLES`-th consecutive low sample after a release.
  - Short-press latency from release is therefore `GAP_CYCLES` cycles.
- A second press whose first high sample arrives while low-sample count ≤ `GAP_CYCLES`-1 yields a double press.
- `double_press` follows the first low sample of the second press.
- After any event the FSM is in IDLE. A high sample on the very next edge starts a new press; no dead cycle is allowed.
- Reset asserted mid-operation:
  - All outputs clear immediately (asynchronously).
  - No pending event is emitted after deassertion.
  - The counter restarts at 0.

## Test plan
Bench parameters: `LONG_CYCLES`=8, `GAP_CYCLES`=4, `CNT_WIDTH`=2.
- Short press: 3 high samples, then low → `short_press` one cycle after the 4th low sample. `press_count`=1. No other pulses.
- Boundary length: 7 high samples, then low → `short_press`, no `long_press`. 8 high samples → `long_press` after the 8th. Holding to 20 samples and releasing produces no further pulse.
- Double press:
  - 3 high, 3 low, 3 high, then low → `double_press` after the first low sample of the second press. `press_count`=2, no `short_press`.
  - Repeating with 4 lows between presses → `short_press` after the 4th low. The second press then ends in its own `short_press`.
- Double window then long: 3 high, 2 low, then 8 high → a single `long_press` after the 8th high, and no `double_press` on release.
- Reset mid-operation: drop `rst_n` during WAIT_SECOND, then release it with the input low → all outputs 0 and `press_count`=0. No `short_press` appears afterwards.
- Wrap and reset-high start:
  - 5 separated short presses → `press_count`=1.
  - Releasing reset with `debounced` high → `press_count`=1 one cycle later.

Source files
------------

// File: rtl/button_event.sv
// rtl/button_event.sv - classify debounced button presses into short/long/double events
module button_event #(
  parameter int LONG_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 debounced,
  output logic                 short_press,
  output logic                 long_press,
  output logic                 double_press,
  output logic [CNT_WIDTH-1:0] press_count
);

  localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0] LONG_T = TW'(LONG_CYCLES);
  localparam logic [TW-1:0] GAP_T  = TW'(GAP_CYCLES);
  localparam logic [TW-1:0] ONE_T  = TW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          prev;

  // Rising-edge press counter; runs independently of the classifier state.
  // prev resets low so a button already held at reset release counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= 1'b0;
      press_count <= '0;
    end else begin
      prev <= debounced;
      if (debounced && !prev) begin
        press_count <= press_count + CNT_WIDTH'(1);
      end
    end
  end

  // Press classifier FSM; event pulses are registered and last one cycle.
  // timer holds the number of consecutive samples of the current level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      case (state)
        IDLE: begin
          if (debounced) begin
            state <= PRESSED;
            timer <= ONE_T;
          end
        end
        PRESSED: begin
          if (debounced) begin
            if (timer + ONE_T == LONG_T) begin
              long_press <= 1'b1;
              state      <= LONG_HELD;
            end else begin
              timer <= timer + ONE_T;
            end
          end else begin
            state <= WAIT_SECOND;
            timer <= ONE_T;
          end
        end
        LONG_HELD: begin
          if (!debounced) begin
            state <= IDLE;
          end
        end
        WAIT_SECOND: begin
          if (!debounced) begin
            if (timer + ONE_T == GAP_T) begin
              short_press <= 1'b1;
              state       <= IDLE;
            end else begin
              timer <= timer + ONE_T;
            end
          end else begin
            state <= SECOND_PRESSED;
            timer <= ONE_T;
          end
        end
        SECOND_PRESSED: begin
          if (!debounced) begin
            double_press <= 1'b1;
            state        <= IDLE;
          end else if (timer + ONE_T == LONG_T) begin
            // Held long enough: the pending double press is dropped.
            long_press <= 1'b1;
            state      <= LONG_HELD;
          end else begin
            timer <= timer + ONE_T;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - directed vector bench for button_event
module tb_button_event;

  logic       clk;
  logic       rst_n;
  logic       debounced;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic [1:0] press_count;

  int total;
  int bad;

  typedef struct {
    logic       din;
    logic       s;
    logic       l;
    logic       d;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[128];
  int   nvec;

  button_event #(
    .LONG_CYCLES(8),
    .GAP_CYCLES (4),
    .CNT_WIDTH  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .debounced   (debounced),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int s, input int l, input int d, input int c);
    check({name, ".short"}, int'(short_press), s);
    check({name, ".long"}, int'(long_press), l);
    check({name, ".double"}, int'(double_press), d);
    check({name, ".count"}, int'(press_count), c);
  endtask

  task automatic push(input logic din, input logic s, input logic l, input logic d, input int cnt);
    vecs[nvec].din = din;
    vecs[nvec].s   = s;
    vecs[nvec].l   = l;
    vecs[nvec].d   = d;
    vecs[nvec].cnt = 2'(cnt);
    nvec++;
  endtask

  task automatic push_n(input int n, input logic din, input int cnt);
    for (int i = 0; i < n; i++) push(din, 1'b0, 1'b0, 1'b0, cnt);
  endtask

  // Drive one sample between edges, then look just after the edge that takes it.
  task automatic step(input logic din);
    @(negedge clk);
    debounced = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    nvec      = 0;
    rst_n     = 1'b0;
    debounced = 1'b0;

    // short press, 3 high
    push_n(3, 1, 1); push_n(3, 0, 1); push(0, 1, 0, 0, 1); push_n(1, 0, 1);
    // 7 high is still short
    push_n(7, 1, 2); push_n(3, 0, 2); push(0, 1, 0, 0, 2); push_n(1, 0, 2);
    // 8 high is long, hold to 20, release silently
    push_n(7, 1, 3); push(1, 0, 1, 0, 3); push_n(12, 1, 3); push_n(5, 0, 3);
    // double press with 3 lows between (count wraps to 0)
    push_n(3, 1, 0); push_n(3, 0, 0); push_n(3, 1, 1); push(0, 0, 0, 1, 1); push_n(4, 0, 1);
    // 4 lows between: two separate shorts, no dead cycle after the first
    push_n(3, 1, 2); push_n(3, 0, 2); push(0, 1, 0, 0, 2);
    push_n(3, 1, 3); push_n(3, 0, 3); push(0, 1, 0, 0, 3); push_n(1, 0, 3);
    // double window, then long second press
    push_n(3, 1, 0); push_n(2, 0, 0); push_n(7, 1, 1); push(1, 0, 1, 0, 1); push_n(5, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].din);
      check_all($sformatf("vec%0d", i), int'(vecs[i].s), int'(vecs[i].l),
                int'(vecs[i].d), int'(vecs[i].cnt));
    end

    // reset asserted during WAIT_SECOND
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0);
    step(1'b0);
    check("pre_reset.count", int'(press_count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset_wait", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      check($sformatf("post_reset%0d.short", i), int'(short_press), 0);
    end
    check("post_reset.count", int'(press_count), 0);

    // reset asserted while a short pulse is high clears it at once
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    check("pulse_before_reset.short", int'(short_press), 1);
    check("pulse_before_reset.count", int'(press_count), 1);
    rst_n = 1'b0;
    #1;
    check_all("async_reset_pulse", 0, 0, 0, 0);

    // reset released with the button already held
    debounced = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("held_start", 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      check($sformatf("held%0d.long", i + 2), int'(long_press), 0);
    end
    step(1'b1);
    check_all("held_long", 0, 1, 0, 1);
    step(1'b0);
    check_all("held_release", 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
